// File: rtl/cpu_pkg.sv
// Shared datapath constants, the ID/EX pipeline register layout and the
// operand forwarding source encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
  } id_ex_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundle of every signal between the operand fetch stage and its neighbours:
// decoded instruction, register file read port, bypass sources and ID/EX outputs.
interface operand_fetch_stage_if #(
  parameter int CNT_W = 16
) ();
  import cpu_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_use_imm;
  logic [DATA_W-1:0] id_imm;

  logic [REG_AW-1:0] regReadSel0;
  logic [REG_AW-1:0] regReadSel1;
  logic [DATA_W-1:0] regReadData0;
  logic [DATA_W-1:0] regReadData1;

  logic [DATA_W-1:0] ex_alu_result;
  logic              mem_reg_write;
  logic [REG_AW-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              flush;
  logic              stall;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [CNT_W-1:0]  stall_count;

  // Operand fetch stage side
  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
    input  id_use_imm, id_imm,
    output regReadSel0, regReadSel1,
    input  regReadData0, regReadData1,
    input  ex_alu_result, mem_reg_write, mem_rd, mem_data,
    input  wb_reg_write, wb_rd, wb_data, flush,
    output stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    output ex_op_a, ex_op_b, stall_count
  );

  // Surrounding pipeline side
  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
    output id_use_imm, id_imm,
    input  regReadSel0, regReadSel1,
    output regReadData0, regReadData1,
    output ex_alu_result, mem_reg_write, mem_rd, mem_data,
    output wb_reg_write, wb_rd, wb_data, flush,
    input  stall, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
    input  ex_op_a, ex_op_b, stall_count
  );

endinterface

// File: rtl/forward_mux.sv
// Priority bypass select for one source register: r0, EX, MEM, WB, then the
// register file. A load in EX is never bypassed; its data is not ready yet.
module forward_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);

  fwd_sel_t sel;

  // Pick the youngest producer of src; r0 short-circuits so r0 writes never bypass
  always_comb begin
    sel = FWD_RF;
    if (src == '0)
      sel = FWD_ZERO;
    else if (ex_valid && ex_reg_write && !ex_mem_read && (ex_rd == src))
      sel = FWD_EX;
    else if (mem_reg_write && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd == src))
      sel = FWD_WB;
  end

  // Steer the selected source onto the operand
  always_comb begin
    data = rf_data;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_EX:   data = ex_alu_result;
      FWD_MEM:  data = mem_data;
      FWD_WB:   data = wb_data;
      default:  data = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand stage: drives register file selects, resolves RAW hazards by
// bypassing, inserts one bubble on load-use and registers operands into ID/EX.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);

  id_ex_t            id_ex_p1;
  logic [CNT_W-1:0]  stall_cnt_p1;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              load_use;
  logic              stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign bus.regReadSel0 = bus.id_rs;
  assign bus.regReadSel1 = bus.id_rt;

  forward_mux u_fwd_rs (
    .src           (bus.id_rs),
    .ex_valid      (id_ex_p1.valid),
    .ex_reg_write  (id_ex_p1.reg_write),
    .ex_mem_read   (id_ex_p1.mem_read),
    .ex_rd         (id_ex_p1.rd),
    .ex_alu_result (bus.ex_alu_result),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .rf_data       (bus.regReadData0),
    .data          (rs_val)
  );

  forward_mux u_fwd_rt (
    .src           (bus.id_rt),
    .ex_valid      (id_ex_p1.valid),
    .ex_reg_write  (id_ex_p1.reg_write),
    .ex_mem_read   (id_ex_p1.mem_read),
    .ex_rd         (id_ex_p1.rd),
    .ex_alu_result (bus.ex_alu_result),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_data      (bus.mem_data),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_data       (bus.wb_data),
    .rf_data       (bus.regReadData1),
    .data          (rt_val)
  );

  // Operand selection and load-use detection; rt only counts when B is not the immediate
  always_comb begin
    op_a     = rs_val;
    op_b     = bus.id_use_imm ? bus.id_imm : rt_val;
    load_use = bus.id_valid && id_ex_p1.valid && id_ex_p1.mem_read &&
               id_ex_p1.reg_write && (id_ex_p1.rd != '0) &&
               ((id_ex_p1.rd == bus.id_rs) ||
                ((id_ex_p1.rd == bus.id_rt) && !bus.id_use_imm));
    stall    = load_use && !bus.flush && rst;
  end

  assign bus.stall = stall;

  // ---- ID/EX boundary (p1) ----
  // Flush squashes, a stall inserts a bubble while ID holds, otherwise advance
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_ex_p1 <= '0;
    end else if (bus.flush) begin
      id_ex_p1.valid <= 1'b0;
    end else if (stall) begin
      id_ex_p1.valid     <= 1'b0;
      id_ex_p1.reg_write <= 1'b0;
      id_ex_p1.mem_read  <= 1'b0;
    end else begin
      id_ex_p1.valid     <= bus.id_valid;
      id_ex_p1.rd        <= bus.id_rd;
      id_ex_p1.reg_write <= bus.id_reg_write && bus.id_valid;
      id_ex_p1.mem_read  <= bus.id_mem_read && bus.id_valid;
      id_ex_p1.op_a      <= op_a;
      id_ex_p1.op_b      <= op_b;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_p1 <= '0;
    else if (stall)
      stall_cnt_p1 <= sat_inc(stall_cnt_p1);
  end

  assign bus.ex_valid     = id_ex_p1.valid;
  assign bus.ex_rd        = id_ex_p1.rd;
  assign bus.ex_reg_write = id_ex_p1.reg_write;
  assign bus.ex_mem_read  = id_ex_p1.mem_read;
  assign bus.ex_op_a      = id_ex_p1.op_a;
  assign bus.ex_op_b      = id_ex_p1.op_b;
  assign bus.stall_count  = stall_cnt_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: stimulus pushes the expected ID/EX
// contents for each issued instruction; a monitor pops on every valid output.
module tb_operand_fetch_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  operand_fetch_stage_if #(.CNT_W(16)) bus ();

  operand_fetch_stage #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    e.a  = a;
    e.b  = b;
    e.rd = rd;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid      = 1'b0;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_rd         = '0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.id_use_imm    = 1'b0;
    bus.id_imm        = '0;
    bus.regReadData0  = '0;
    bus.regReadData1  = '0;
    bus.ex_alu_result = '0;
    bus.mem_reg_write = 1'b0;
    bus.mem_rd        = '0;
    bus.mem_data      = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_rd         = '0;
    bus.wb_data       = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [31:0] rf0,
                       input logic [31:0] rf1);
    bus.id_valid     = 1'b1;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.regReadData0 = rf0;
    bus.regReadData1 = rf1;
  endtask

  // Monitor: every valid ID/EX output must match the oldest expectation
  always @(negedge clk) begin
    if (bus.ex_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got ex_valid=1 rd=%0d expected no output", bus.ex_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ex_op_a", bus.ex_op_a, e.a);
        chk("ex_op_b", bus.ex_op_b, e.b);
        chk("ex_rd", {27'd0, bus.ex_rd}, {27'd0, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b0;
    // Reset with a live instruction presented
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h100, 32'h200);
    cyc();
    cyc();
    chk("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("reset_ex_op_a", bus.ex_op_a, 32'd0);
    chk("reset_stall_count", {16'd0, bus.stall_count}, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b1;

    // A: plain register file read, writes r3
    idle();
    instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h100, 32'h200);
    chk("sel0", {27'd0, bus.regReadSel0}, 32'd1);
    chk("sel1", {27'd0, bus.regReadSel1}, 32'd2);
    push(32'h100, 32'h200, 5'd3);
    #2 chk("A_stall", {31'd0, bus.stall}, 32'd0);
    cyc();

    // B: EX bypass of r3
    idle();
    instr(5'd3, 5'd0, 5'd4, 1'b0, 1'b0, 32'h11, 32'h99);
    bus.ex_alu_result = 32'h0000_00AA;
    push(32'h0000_00AA, 32'h0, 5'd4);
    cyc();

    // C: MEM beats WB for r5
    idle();
    instr(5'd6, 5'd5, 5'd8, 1'b0, 1'b0, 32'h66, 32'h55);
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'h22;
    bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_data  = 32'h33;
    push(32'h66, 32'h22, 5'd8);
    cyc();

    // D: only WB remains
    bus.mem_reg_write = 1'b0;
    push(32'h66, 32'h33, 5'd8);
    cyc();

    // E: load to r7
    idle();
    instr(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h100, 32'h200);
    push(32'h100, 32'h200, 5'd7);
    cyc();

    // F: dependent on the load -> stall, no output
    idle();
    instr(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 32'h77, 32'h0);
    #2 chk("F_stall", {31'd0, bus.stall}, 32'd1);
    cyc();
    chk("F_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("F_stall_count", {16'd0, bus.stall_count}, 32'd1);

    // G: held instruction now takes the MEM bypass
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'hDEAD_BEEF;
    push(32'hDEAD_BEEF, 32'h0, 5'd9);
    #2 chk("G_stall", {31'd0, bus.stall}, 32'd0);
    cyc();

    // H: another load to r7
    idle();
    instr(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h100, 32'h200);
    push(32'h100, 32'h200, 5'd7);
    cyc();

    // I: load-use with flush -> no stall, no count
    idle();
    instr(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 32'h77, 32'h0);
    bus.flush = 1'b1;
    #2 chk("I_flush_stall", {31'd0, bus.stall}, 32'd0);
    cyc();
    chk("I_flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("I_stall_count", {16'd0, bus.stall_count}, 32'd1);

    // J: r0 with MEM/WB claiming r0 writes; issue load to r7
    idle();
    instr(5'd0, 5'd2, 5'd7, 1'b1, 1'b1, 32'h1234_5678, 32'h200);
    bus.wb_reg_write  = 1'b1; bus.wb_rd  = 5'd0; bus.wb_data  = 32'hFFFF_FFFF;
    bus.mem_reg_write = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h0000_ABCD;
    push(32'h0, 32'h200, 5'd7);
    cyc();

    // K: immediate operand B, rt matches pending load -> no stall
    idle();
    instr(5'd1, 5'd7, 5'd10, 1'b0, 1'b0, 32'h100, 32'h77);
    bus.id_use_imm = 1'b1;
    bus.id_imm     = 32'hFFFF_FFFC;
    push(32'h100, 32'hFFFF_FFFC, 5'd10);
    #2 chk("K_imm_stall", {31'd0, bus.stall}, 32'd0);
    cyc();

    // L: load to r7
    idle();
    instr(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h100, 32'h200);
    push(32'h100, 32'h200, 5'd7);
    cyc();

    // M: dependent instruction while reset asserted
    idle();
    instr(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 32'h77, 32'h0);
    rst = 1'b0;
    #2 chk("M_rst_stall", {31'd0, bus.stall}, 32'd0);
    cyc();
    chk("M_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("M_rst_stall_count", {16'd0, bus.stall_count}, 32'd0);

    rst = 1'b1;
    idle();
    cyc();
    cyc();
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
